// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types for the pipeline hazard/stall controller
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
  } shadow_entry_t;

  typedef enum logic {S_RUN, S_MEM_WAIT} ctrl_state_t;

  // A shadow entry produces register r unless it is empty, silent, or targets r0.
  function automatic logic reg_match(shadow_entry_t e, logic [4:0] r);
    return e.valid & e.wb_en & (e.dest != REG_ZERO) & (e.dest == r);
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// rtl/hazard_shadow_stage.sv - one shadow pipeline entry with enable and bubble insert
module hazard_shadow_stage
  import pipe_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic          bubble_i,
  input  shadow_entry_t entry_i,
  output shadow_entry_t entry_o
);

  shadow_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (en_i) entry_d = bubble_i ? '0 : entry_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - ID-stage hazard detection, stall/flush/freeze control and statistics
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN  = 1'b1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_use_src2,
  input  logic [4:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic             id_is_branch,
  input  logic             id_br_taken,
  input  logic             dmem_ready,
  output logic             hazard_detected,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  shadow_entry_t     ex_q, mem_q, id_entry;
  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic              raw_ex, raw_mem, mem_busy;

  assign id_entry = '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en,
                      mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en};

  assign raw_ex  = reg_match(ex_q, id_src1)  | (id_use_src2 & reg_match(ex_q, id_src2));
  assign raw_mem = reg_match(mem_q, id_src1) | (id_use_src2 & reg_match(mem_q, id_src2));

  // Branches resolve in ID, so forwarding into EX never helps them.
  assign hazard_detected = id_valid & ((raw_ex & ex_q.mem_r_en)
                                     | (id_is_branch & (raw_ex | raw_mem))
                                     | ((FORWARD_EN == 1'b0) & (raw_ex | raw_mem)));

  assign mem_busy    = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en);
  assign pipe_freeze = mem_busy & ~dmem_ready;
  assign pc_write    = ~(hazard_detected | pipe_freeze);
  assign ifid_write  = pc_write;
  assign ifid_flush  = id_valid & id_br_taken & ~hazard_detected & ~pipe_freeze;

  hazard_shadow_stage u_ex_stage (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (~pipe_freeze),
    .bubble_i (hazard_detected | ~id_valid),
    .entry_i  (id_entry),
    .entry_o  (ex_q)
  );

  hazard_shadow_stage u_mem_stage (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (~pipe_freeze),
    .bubble_i (1'b0),
    .entry_i  (ex_q),
    .entry_o  (mem_q)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    timeout_d = timeout_q | (wait_q == WAIT_MAX);
    case (state_q)
      S_RUN: begin
        wait_d = '0;
        if (pipe_freeze) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
    if (hazard_detected & ~pipe_freeze & ~(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (ifid_flush & ~(&flush_q))                      flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - checks both forwarding variants against an instruction-level model
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rstn;
  logic id_valid, id_use_src2, id_wb_en, id_mem_r_en, id_mem_w_en;
  logic id_is_branch, id_br_taken, dmem_ready;
  logic [4:0] id_src1, id_src2, id_dest;

  logic haz [2], pcw [2], ifw [2], flu [2], frz [2], tmo [2];
  logic [CNT_W-1:0] scnt [2], fcnt [2];

  typedef struct {bit v; int d; bit wb; bit rd; bit wr;} ins_t;
  ins_t m_ex [2], m_mem [2];
  int   m_stall [2], m_flush [2], m_run [2];
  bit   m_tmo [2];

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FORWARD_EN(1'b0), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) u_nofwd (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_is_branch(id_is_branch),
    .id_br_taken(id_br_taken), .dmem_ready(dmem_ready), .hazard_detected(haz[0]),
    .pc_write(pcw[0]), .ifid_write(ifw[0]), .ifid_flush(flu[0]), .pipe_freeze(frz[0]),
    .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]), .mem_timeout(tmo[0]));

  hazard_stall_ctrl #(.FORWARD_EN(1'b1), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) u_fwd (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_is_branch(id_is_branch),
    .id_br_taken(id_br_taken), .dmem_ready(dmem_ready), .hazard_detected(haz[1]),
    .pc_write(pcw[1]), .ifid_write(ifw[1]), .ifid_flush(flu[1]), .pipe_freeze(frz[1]),
    .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]), .mem_timeout(tmo[1]));

  task automatic chk(string tag, int f, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s fwd=%0d observed=%0h expected=%0h t=%0t", tag, f, obs, exp, $time);
    end
  endtask

  function automatic bit produces(ins_t e, int r);
    return e.v && e.wb && (e.d != 0) && (e.d == r);
  endfunction

  function automatic bit reads_from(ins_t e);
    return produces(e, int'(id_src1)) || (id_use_src2 && produces(e, int'(id_src2)));
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      m_ex[f]    = '{0, 0, 0, 0, 0};
      m_mem[f]   = '{0, 0, 0, 0, 0};
      m_stall[f] = 0;
      m_flush[f] = 0;
      m_run[f]   = 0;
      m_tmo[f]   = 0;
    end
  endtask

  // Compare both DUTs against the model for the current inputs; optionally retire the cycle.
  task automatic eval(bit advance);
    bit busy, fz, dex, dmem, hz, fl;
    ins_t id_ins;
    for (int f = 0; f < 2; f++) begin
      busy = m_mem[f].v && (m_mem[f].rd || m_mem[f].wr);
      fz   = busy && !dmem_ready;
      dex  = reads_from(m_ex[f]);
      dmem = reads_from(m_mem[f]);
      hz   = id_valid && ((dex && m_ex[f].rd) || (id_is_branch && (dex || dmem)) ||
                          (f == 0 && (dex || dmem)));
      fl   = id_valid && id_br_taken && !hz && !fz;
      chk("hazard_detected", f, 32'(haz[f]), 32'(hz));
      chk("pc_write",        f, 32'(pcw[f]), 32'(!(hz || fz)));
      chk("ifid_write",      f, 32'(ifw[f]), 32'(!(hz || fz)));
      chk("ifid_flush",      f, 32'(flu[f]), 32'(fl));
      chk("pipe_freeze",     f, 32'(frz[f]), 32'(fz));
      chk("stall_cnt",       f, 32'(scnt[f]), 32'(m_stall[f]));
      chk("flush_cnt",       f, 32'(fcnt[f]), 32'(m_flush[f]));
      chk("mem_timeout",     f, 32'(tmo[f]), 32'(m_tmo[f]));
      if (advance) begin
        id_ins = '{1, int'(id_dest), id_wb_en, id_mem_r_en, id_mem_w_en};
        if (!fz) begin
          m_mem[f] = m_ex[f];
          m_ex[f]  = (hz || !id_valid) ? '{0, 0, 0, 0, 0} : id_ins;
        end
        if (hz && !fz && m_stall[f] < CMAX) m_stall[f]++;
        if (fl && m_flush[f] < CMAX) m_flush[f]++;
        // The first frozen cycle is spent entering the wait state, hence TMO+1 prior cycles.
        if (m_run[f] >= TMO + 1) m_tmo[f] = 1;
        m_run[f] = fz ? m_run[f] + 1 : 0;
      end
    end
  endtask

  task automatic step(bit v, int s1, int s2, bit u2, int d, bit wb, bit rd, bit wr,
                      bit br, bit tk, bit rdy);
    id_valid = v;  id_src1 = 5'(s1); id_src2 = 5'(s2); id_use_src2 = u2;
    id_dest = 5'(d); id_wb_en = wb; id_mem_r_en = rd; id_mem_w_en = wr;
    id_is_branch = br; id_br_taken = tk; dmem_ready = rdy;
    #1;
    eval(1'b1);
    @(negedge clk);
  endtask

  task automatic nop(int n, bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    id_valid = 0; id_br_taken = 0; id_is_branch = 0;
    model_reset();
    #1;
    eval(1'b0);
  endtask

  initial begin
    id_src1 = 0; id_src2 = 0; id_dest = 0; id_use_src2 = 0; id_wb_en = 0;
    id_mem_r_en = 0; id_mem_w_en = 0; dmem_ready = 1;
    do_reset();
    @(negedge clk);
    eval(1'b0);
    rstn = 1'b1;

    // load r3, then add r4 = r3 + r1 held in ID until it issues
    step(1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1);
    step(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1);
    step(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1);
    step(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1);
    nop(3, 1);
    // add r5, then sub r6 = r5 - r1
    step(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 5, 1, 1, 6, 1, 0, 0, 0, 0, 1);
    nop(3, 1);
    // add r7, then taken BNE r7, r2
    step(1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 7, 2, 1, 0, 0, 0, 0, 1, 1, 1);
    nop(3, 1);
    // load r0, then add using r0
    step(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 8, 1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 8, 1, 0, 0, 0, 0, 1);
    nop(3, 1);
    // store with a 3-cycle memory wait
    step(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    nop(1, 1);
    nop(3, 0);
    nop(3, 1);

    for (int i = 0; i < 400; i++)
      step($urandom % 8 != 0, $urandom % 4, $urandom % 4, 1'($urandom), $urandom % 4,
           1'($urandom), $urandom % 3 == 0, $urandom % 4 == 0, $urandom % 3 == 0,
           1'($urandom), $urandom % 5 != 0);
    nop(3, 1);

    // long memory wait crossing the timeout, then reset while still waiting
    step(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    nop(1, 1);
    nop(70, 0);
    do_reset();
    @(negedge clk);
    rstn = 1'b1;
    nop(3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage core; sits beside the decode stage.
- Keeps a shadow copy of the destination-register info in the EX and MEM stages. From this it detects data hazards for the instruction in ID.
- Drives hazard_detected into decode and gates PC / IF-ID writes. Flushes IF/ID on taken branches. Freezes the whole pipe while data memory is not ready.
- Also keeps stall/flush statistics and a memory-timeout flag.

Parameters:
- FORWARD_EN, 1, 1 = EX/MEM forwarding exists (only load-use stalls ALU ops); 0 = stall on any RAW against EX or MEM
- CNT_W, 16, width of the saturating stall_cnt and flush_cnt counters
- MEM_TIMEOUT, 64, consecutive MEM_WAIT cycles before mem_timeout is set

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  5  ID rs
- id_src2  in  5  ID second source (already muxed for ST/BNE)
- id_use_src2  in  1  second source is read (reg-reg, ST, BNE)
- id_dest  in  5  ID destination register
- id_wb_en  in  1  ID instruction writes back
- id_mem_r_en  in  1  ID instruction is a load
- id_mem_w_en  in  1  ID instruction is a store
- id_is_branch  in  1  ID instruction is a conditional branch (operands read in ID)
- id_br_taken  in  1  branch taken, from ID condition check
- dmem_ready  in  1  data memory completes the access this cycle
- hazard_detected  out  1  to decode controller; forces control signals to bubble
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID at next edge
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- stall_cnt  out  CNT_W  hazard stall cycles, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating
- mem_timeout  out  1  sticky, set on memory wait timeout

Behaviour:
- Single clock clk. Reset rstn is asynchronous, active-low.
- Reset state:
  - ex_q.valid = 0, mem_q.valid = 0, state = S_RUN, wait_cnt = 0.
  - stall_cnt = 0, flush_cnt = 0, mem_timeout = 0.
  - Combinational outputs at reset: hazard_detected = 0, pc_write = 1, ifid_write = 1, ifid_flush = 0, pipe_freeze = 0.
- Shadow entry format: {valid, dest[4:0], wb_en, mem_r_en, mem_w_en}.
- Match(e, r) = e.valid & e.wb_en & (e.dest != 0) & (e.dest == r).
- RAW(e) = Match(e, id_src1) | (id_use_src2 & Match(e, id_src2)).
- Hazard logic (combinational; all terms gated by id_valid):
  - Load-use: RAW(ex_q) & ex_q.mem_r_en.
  - Branch: id_is_branch & (RAW(ex_q) | RAW(mem_q)). This applies regardless of FORWARD_EN.
  - FORWARD_EN = 0 only: RAW(ex_q) | RAW(mem_q) for any instruction.
  - hazard_detected = OR of the applicable terms above.
- Freeze: mem_busy = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en); pipe_freeze = mem_busy & ~dmem_ready.
- Enables: pc_write = ifid_write = ~(hazard_detected | pipe_freeze).
- Flush: ifid_flush = id_valid & id_br_taken & ~hazard_detected & ~pipe_freeze. A branch whose operands are stale never flushes.
- Shadow advance on each edge when ~pipe_freeze:
  - mem_q <= ex_q.
  - ex_q <= bubble (valid = 0) if hazard_detected or ~id_valid; otherwise the ID fields.
  - While pipe_freeze is high, both shadow entries hold.
- FSM (state enum):
  - S_RUN -> S_MEM_WAIT when pipe_freeze.
  - S_MEM_WAIT -> S_RUN when dmem_ready.
- wait_cnt:
  - Increments each cycle spent in S_MEM_WAIT with ~dmem_ready. It holds at MEM_TIMEOUT rather than continuing.
  - Clears on returning to S_RUN.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout <= 1 and stays 1 until rstn.
- Counters:
  - stall_cnt increments on hazard_detected & ~pipe_freeze.
  - flush_cnt increments on ifid_flush.
  - Both saturate at all-ones.
- Priority: freeze > hazard stall > flush.
- Simultaneous hazard and branch taken: stall only, no flush. The branch re-evaluates next cycle.
- Reset asserted mid-MEM_WAIT: all state returns to the reset values immediately.
- Register 0 as destination never causes a hazard.

Decomposition:
- Package pipe_ctrl_pkg contains:
  - shadow_entry_t packed struct
  - ctrl_state_t enum {S_RUN, S_MEM_WAIT}
  - localparam REG_ZERO = 5'd0
- One sub-module, hazard_shadow_stage: a single shadow register with enable, bubble insert and async reset. It is instantiated twice (ex_q, mem_q).

Test Plan:
- Load-use: load r3 (dest 3, mem_r_en) then add r4 = r3 + r1, FORWARD_EN = 1 -> hazard_detected = 1 for exactly 1 cycle; pc_write = 0; stall_cnt = 1; ex_q bubble, then the add proceeds.
- ALU RAW with forwarding: add r5 then sub using r5, FORWARD_EN = 1 -> no stall. Same sequence with FORWARD_EN = 0 -> 2 stall cycles; stall_cnt = 2.
- Branch dependency: add r7 then BNE r7, r2, taken -> 2 stall cycles with ifid_flush = 0; then ifid_flush = 1 for 1 cycle; flush_cnt = 1.
- Memory wait: store reaches MEM with dmem_ready held low 3 cycles -> pipe_freeze = 1 for 3 cycles; shadow entries hold; state returns to S_RUN the cycle dmem_ready = 1.
- Timeout and reset: dmem_ready low 70 cycles, MEM_TIMEOUT = 64 -> mem_timeout = 1 from cycle 64 and sticky. Drop rstn mid-wait -> all outputs return to reset values asynchronously.
- Register zero: load r0 then add using r0 -> no hazard_detected; stall_cnt unchanged.
